// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count and sticky error flags.
// Define FIFO_SYNC_FWFT_EN for a first-word-fall-through read port; default is a registered read.
module fifo_sync_param #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned AFULL_TH  = 2**ASIZE - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 2**ASIZE;
  localparam logic [ASIZE:0] AFullTh  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEmptyTh = (ASIZE+1)'(AEMPTY_TH);

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [DSIZE-1:0] mem_q [DEPTH];
  logic             wr_acc, rd_acc;
  logic [ASIZE-1:0] waddr, raddr;

  // Status decode from registered pointers only; the wrap bit separates full from empty.
  always_comb begin
    empty        = (wptr_q == rptr_q);
    full         = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                   (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    count        = wptr_q - rptr_q;
    almost_full  = (count >= AFullTh);
    almost_empty = (count <= AEmptyTh);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  always_comb begin
    wr_acc = wr_en & ~full;
    rd_acc = rd_en & ~empty;
    waddr  = wptr_q[ASIZE-1:0];
    raddr  = rptr_q[ASIZE-1:0];
    wptr_d = wr_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_acc ? rptr_q + 1'b1 : rptr_q;
  end

  // Sticky error flags; a clear in the same cycle as a new error wins.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr] <= wdata;
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is presented combinationally; rdata is forced to zero while nothing is stored.
  always_comb begin
    rd_valid = ~empty;
    rdata    = empty ? '0 : mem_q[raddr];
  end
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    rdata_d    = rd_acc ? mem_q[raddr] : rdata_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    rdata    = rdata_q;
    rd_valid = rd_valid_q;
  end
`endif

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO, successor to the team's fixed synchronous FIFO memory block. Provides the storage plus full pointer/flag control: full/empty, programmable almost-full/almost-empty thresholds, occupancy count and sticky overflow/underflow error flags. A compile-time macro switches the read port between registered-output mode and first-word-fall-through (FWFT) mode. Sits between any same-clock producer/consumer pair in the datapath.

## Interface

Parameters:
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; DEPTH = 2^ASIZE entries
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH (range 1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (range 0..DEPTH-1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wdata  in  DSIZE  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge of rdata)
- clr_err  in  1  synchronous clear of overflow/underflow
- rdata  out  DSIZE  read data
- rd_valid  out  1  rdata valid
- full, empty  out  1  occupancy flags
- almost_full, almost_empty  out  1  threshold flags
- count  out  ASIZE+1  occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

## Operation

- Pointers wptr/rptr are ASIZE+1 bits; low ASIZE bits address memory, MSB is wrap bit. empty = (wptr == rptr); full = MSBs differ, low bits equal. count = wptr - rptr modulo 2^(ASIZE+1).
- wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. No write pass-through when full, even with simultaneous read.
- wr_acc: mem[wptr] <= wdata, wptr++. rd_acc: rptr++. Both: count unchanged.
- Simultaneous write and read on empty FIFO: write accepted, read rejected, underflow set.
- wr_en & full sets overflow; rd_en & empty sets underflow. Both hold until clr_err (clr_err wins over a same-cycle set) or reset.
- Pointer wrap from 2^(ASIZE+1)-1 to 0 is natural modulo rollover; no special case.
- Reset: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow/underflow 0, rd_valid 0, rdata 0. Memory contents not reset. Reset mid-operation discards all stored data.

## Timing

- Flags and count are decoded from registered pointers; they reflect an accepted operation in the cycle after its clock edge.
- Registered mode: on rd_acc edge rdata <= mem[rptr]; rd_valid is 1 for exactly the following cycle per accepted read; rdata holds its value otherwise. Read latency 1 cycle.
- FWFT mode: rdata = mem[rptr[ASIZE-1:0]] combinationally, rd_valid = ~empty. A word written into an empty FIFO appears on rdata the cycle after the write edge. rd_en while rd_valid consumes the presented word.
- Throughput: one write and one read per cycle sustained.

## Configuration

- FIFO_SYNC_FWFT_EN defined: FWFT read port as above, no output register.
- Not defined: registered-output mode, 1-cycle read latency, rd_valid is a one-cycle strobe.
- Flags, count, error logic identical in both builds.

## Test plan

- Reset, DSIZE=8 ASIZE=4: write 0x00..0x0F -> full=1 and count=16 after last edge, almost_full=1 from count 14; read all 16 -> data 0x00..0x0F in order, empty=1.
- Write on full (wdata 0xAA) -> write ignored, overflow=1 stays high; clr_err pulse -> overflow=0; next reads contain no 0xAA.
- Read on empty -> underflow=1, rd_valid stays 0, count stays 0.
- Fill to 8, then 40 cycles simultaneous write/read -> count stays 8, pointers wrap twice, output sequence continuous without loss.
- FWFT build: single write 0x5C to empty -> next cycle rd_valid=1, rdata=0x5C with no rd_en; registered build: rd_en -> rdata=0x5C one cycle later with one-cycle rd_valid.
- Assert rst_n low mid-burst with count=5 -> all outputs to reset values immediately (asynchronous), count=0 after release.
